// File: rtl/imager_capture_ctrl_pkg.sv
// Shared word-type and capture-mode encodings for the imager datapath.
package imager_capture_ctrl_pkg;

    localparam int DTYPE_WIDTH = 3;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_NONE        = 3'd0;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 3'd1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 3'd2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 3'd3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 3'd4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 3'd5;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SINGLE  = 2'd1;
    localparam logic [1:0] MODE_NFRAMES = 2'd2;
    localparam logic [1:0] MODE_CONT    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/imager_capture_ctrl.sv
// Frame capture sequencer: passes only whole frames (FRAME_START..FRAME_END)
// in single, N-frame or continuous mode, with per-frame statistics.
module imager_capture_ctrl
    import imager_capture_ctrl_pkg::*;
#(
    parameter int PIXEL_WIDTH     = 12,
    parameter int COUNT_WIDTH     = 16,
    parameter int PIX_COUNT_WIDTH = 32
) (
    input  logic                       clki,
    input  logic                       resetb,
    input  logic [1:0]                 mode,
    input  logic [COUNT_WIDTH-1:0]     num_frames,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       dvi,
    input  logic [DTYPE_WIDTH-1:0]     dtypei,
    input  logic [PIXEL_WIDTH-1:0]     datai,
    output logic                       dvo,
    output logic [DTYPE_WIDTH-1:0]     dtypeo,
    output logic [PIXEL_WIDTH-1:0]     datao,
    output logic                       busy,
    output logic                       done,
    output logic [COUNT_WIDTH-1:0]     frames_captured,
    output logic [COUNT_WIDTH-1:0]     frames_dropped,
    output logic [PIX_COUNT_WIDTH-1:0] last_frame_pixels
);

    cap_state_t                 state_q, state_d;
    logic [1:0]                 mode_q;
    logic [COUNT_WIDTH-1:0]     target_q;
    logic                       stop_pending_q, stop_pending_d;
    logic [PIX_COUNT_WIDTH-1:0] pix_cnt_q;

    logic                       is_fs, is_fe, is_pix;
    logic                       fwd, accept_start, cnt_clr, fe_hit, fs_drop, seq_done, finish;
    logic [COUNT_WIDTH-1:0]     fc_inc;

    assign is_fs  = dvi && (dtypei == DTYPE_FRAME_START);
    assign is_fe  = dvi && (dtypei == DTYPE_FRAME_END);
    assign is_pix = dvi && (dtypei == DTYPE_PIXEL);
    assign fc_inc = frames_captured + 1'b1;

    // State and stop-request registers.
    always_ff @(posedge clki or negedge resetb) begin
        if (!resetb) begin
            state_q        <= ST_IDLE;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    // Next-state decode and per-cycle datapath/counter controls.
    always_comb begin
        state_d        = state_q;
        stop_pending_d = stop_pending_q;
        fwd            = 1'b0;
        accept_start   = 1'b0;
        cnt_clr        = 1'b0;
        fe_hit         = 1'b0;
        fs_drop        = 1'b0;
        seq_done       = 1'b0;
        finish         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stop_pending_d = 1'b0;
                // stop in the same cycle as start cancels the request
                if (start && !stop && (mode != MODE_OFF)) begin
                    accept_start = 1'b1;
                    state_d      = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // no frame is open, so stop returns to IDLE without done
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (is_fs) begin
                    fwd     = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                fwd = dvi;
                if (stop) stop_pending_d = 1'b1;
                if (is_fe) begin
                    fe_hit = 1'b1;
                    finish = (mode_q == MODE_SINGLE) ||
                             ((mode_q == MODE_NFRAMES) && (fc_inc >= target_q)) ||
                             stop_pending_q || stop;
                    if (finish) begin
                        state_d        = ST_IDLE;
                        seq_done       = 1'b1;
                        stop_pending_d = 1'b0;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end else if (is_fs) begin
                    // previous frame never ended: count it as aborted, restart
                    fs_drop = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture configuration latched on an accepted start.
    always_ff @(posedge clki or negedge resetb) begin
        if (!resetb) begin
            mode_q   <= MODE_OFF;
            target_q <= '0;
        end else if (accept_start) begin
            mode_q   <= mode;
            target_q <= (num_frames == '0) ? COUNT_WIDTH'(1) : num_frames;
        end
    end

    // Pixel counter for the frame currently being captured.
    always_ff @(posedge clki or negedge resetb) begin
        if (!resetb) begin
            pix_cnt_q <= '0;
        end else if (cnt_clr) begin
            pix_cnt_q <= '0;
        end else if ((state_q == ST_CAPTURE) && is_pix) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
        end
    end

    // Output stage: one-cycle forwarded word plus registered status/statistics.
    always_ff @(posedge clki or negedge resetb) begin
        if (!resetb) begin
            dvo               <= 1'b0;
            dtypeo            <= '0;
            datao             <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            frames_captured   <= '0;
            frames_dropped    <= '0;
            last_frame_pixels <= '0;
        end else begin
            dvo  <= fwd;
            busy <= (state_d != ST_IDLE);
            done <= seq_done;
            if (fwd) begin
                dtypeo <= dtypei;
                datao  <= datai;
            end
            if (accept_start) begin
                frames_captured <= '0;
                frames_dropped  <= '0;
            end
            if (fe_hit) begin
                frames_captured   <= fc_inc;
                last_frame_pixels <= pix_cnt_q;
            end
            if (fs_drop) frames_dropped <= frames_dropped + 1'b1;
        end
    end

endmodule

// File: tb/tb_imager_capture_ctrl.sv
// Directed self-checking bench for imager_capture_ctrl.
module tb_imager_capture_ctrl;
    import imager_capture_ctrl_pkg::*;

    logic        clki = 1'b0;
    logic        resetb;
    logic [1:0]  mode;
    logic [15:0] num_frames;
    logic        start, stop, dvi;
    logic [2:0]  dtypei;
    logic [11:0] datai;
    logic        dvo, busy, done;
    logic [2:0]  dtypeo;
    logic [11:0] datao;
    logic [15:0] frames_captured, frames_dropped;
    logic [31:0] last_frame_pixels;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int out_fs = 0, out_px = 0, out_fe = 0, out_other = 0, done_cnt = 0;
    int b_fs, b_px, b_fe, b_other, b_done;

    imager_capture_ctrl dut (
        .clki(clki), .resetb(resetb), .mode(mode), .num_frames(num_frames),
        .start(start), .stop(stop), .dvi(dvi), .dtypei(dtypei), .datai(datai),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .busy(busy), .done(done),
        .frames_captured(frames_captured), .frames_dropped(frames_dropped),
        .last_frame_pixels(last_frame_pixels)
    );

    always #5 clki = ~clki;

    // Output word and done-pulse tally, sampled on the falling edge.
    always @(negedge clki) begin
        if (dvo) begin
            if (dtypeo == DTYPE_FRAME_START) out_fs++;
            else if (dtypeo == DTYPE_PIXEL) out_px++;
            else if (dtypeo == DTYPE_FRAME_END) out_fe++;
            else out_other++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_fs = out_fs; b_px = out_px; b_fe = out_fe; b_other = out_other; b_done = done_cnt;
    endtask

    task automatic step(input logic v, input logic [2:0] t, input logic [11:0] d,
                        input logic st, input logic sp);
        @(negedge clki);
        dvi = v; dtypei = t; datai = d; start = st; stop = sp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, DTYPE_NONE, 12'd0, 1'b0, 1'b0);
    endtask

    // One frame of rows x cols pixels; stop asserted on pixel number stop_at (-1: never).
    task automatic frame(input int rows, input int cols, input int stop_at);
        int p;
        p = 0;
        step(1'b1, DTYPE_FRAME_START, 12'h0F1, 1'b0, 1'b0);
        for (int r = 0; r < rows; r++) begin
            step(1'b1, DTYPE_ROW_START, 12'h0A0, 1'b0, 1'b0);
            for (int c = 0; c < cols; c++) begin
                step(1'b1, DTYPE_PIXEL, 12'(p), 1'b0, (p == stop_at));
                p++;
            end
            step(1'b1, DTYPE_ROW_END, 12'h0B0, 1'b0, 1'b0);
        end
        step(1'b1, DTYPE_FRAME_END, 12'hABC, 1'b0, 1'b0);
    endtask

    initial begin
        resetb = 1'b0; mode = MODE_OFF; num_frames = 16'd0;
        start = 1'b0; stop = 1'b0; dvi = 1'b0; dtypei = '0; datai = '0;
        idle(3);
        check("rst_dvo", dvo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fc", frames_captured, 0);
        check("rst_lfp", last_frame_pixels, 0);
        resetb = 1'b1;
        idle(2);

        // Single shot: only the first of three frames passes
        snap();
        mode = MODE_SINGLE;
        step(1'b0, DTYPE_NONE, 12'd0, 1'b1, 1'b0);
        idle(1);
        check("t1_busy_after_start", busy, 1);
        frame(4, 8, -1); frame(4, 8, -1); frame(4, 8, -1);
        idle(2);
        check("t1_fs", out_fs - b_fs, 1);
        check("t1_px", out_px - b_px, 32);
        check("t1_fe", out_fe - b_fe, 1);
        check("t1_done", done_cnt - b_done, 1);
        check("t1_lfp", last_frame_pixels, 32);
        check("t1_fc", frames_captured, 1);
        check("t1_busy", busy, 0);
        check("t1_dtypeo_held", dtypeo, DTYPE_FRAME_END);
        check("t1_datao_held", datao, 12'hABC);

        // N frames (3), start 5 cycles before a mid-frame ROW_START
        snap();
        mode = MODE_NFRAMES; num_frames = 16'd3;
        step(1'b1, DTYPE_FRAME_START, 12'h0F1, 1'b0, 1'b0);
        step(1'b1, DTYPE_ROW_START, 12'h0A0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, DTYPE_PIXEL, 12'(i), (i == 4), 1'b0);
        step(1'b1, DTYPE_ROW_END, 12'h0B0, 1'b0, 1'b0);
        step(1'b1, DTYPE_ROW_START, 12'h0A0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, DTYPE_PIXEL, 12'(i), 1'b0, 1'b0);
        step(1'b1, DTYPE_ROW_END, 12'h0B0, 1'b0, 1'b0);
        step(1'b1, DTYPE_FRAME_END, 12'hABC, 1'b0, 1'b0);
        idle(2);
        check("t2_partial_dropped", out_other - b_other, 0);
        check("t2_partial_busy", busy, 1);
        frame(2, 4, -1); frame(2, 4, -1);
        idle(2);
        check("t2_fc_after2", frames_captured, 2);
        check("t2_no_done_yet", done_cnt - b_done, 0);
        frame(2, 4, -1);
        idle(2);
        check("t2_fc", frames_captured, 3);
        check("t2_done", done_cnt - b_done, 1);
        check("t2_busy", busy, 0);
        frame(2, 4, -1);
        idle(2);
        check("t2_fs", out_fs - b_fs, 3);
        check("t2_px", out_px - b_px, 24);
        check("t2_rows", out_other - b_other, 12);

        // Continuous, stop mid-frame 2: frame 2 completes
        snap();
        mode = MODE_CONT;
        step(1'b0, DTYPE_NONE, 12'd0, 1'b1, 1'b0);
        frame(2, 4, -1);
        frame(2, 4, 2);
        frame(2, 4, -1);
        idle(2);
        check("t3_fs", out_fs - b_fs, 2);
        check("t3_px", out_px - b_px, 16);
        check("t3_fe", out_fe - b_fe, 2);
        check("t3_fc", frames_captured, 2);
        check("t3_done", done_cnt - b_done, 1);
        check("t3_busy", busy, 0);

        // Continuous, FRAME_START injected without FRAME_END
        snap();
        step(1'b0, DTYPE_NONE, 12'd0, 1'b1, 1'b0);
        frame(2, 4, -1);
        step(1'b1, DTYPE_FRAME_START, 12'h0F1, 1'b0, 1'b0);
        step(1'b1, DTYPE_ROW_START, 12'h0A0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, DTYPE_PIXEL, 12'(i), 1'b0, 1'b0);
        step(1'b1, DTYPE_FRAME_START, 12'h123, 1'b0, 1'b0);
        step(1'b1, DTYPE_ROW_START, 12'h0A0, 1'b0, 1'b0);
        check("t4_latency_dvo", dvo, 1);
        check("t4_latency_data", datao, 12'h123);
        for (int i = 0; i < 4; i++) step(1'b1, DTYPE_PIXEL, 12'(i), 1'b0, 1'b0);
        step(1'b1, DTYPE_ROW_END, 12'h0B0, 1'b0, 1'b0);
        step(1'b1, DTYPE_FRAME_END, 12'hABC, 1'b0, 1'b0);
        idle(2);
        check("t4_fd", frames_dropped, 1);
        check("t4_fc", frames_captured, 2);
        check("t4_lfp", last_frame_pixels, 4);
        check("t4_busy_armed", busy, 1);
        step(1'b0, DTYPE_NONE, 12'd0, 1'b0, 1'b1);
        idle(2);
        check("t4_busy", busy, 0);
        check("t4_no_done", done_cnt - b_done, 0);
        check("t4_fs", out_fs - b_fs, 3);
        check("t4_px", out_px - b_px, 15);

        // start and stop together: ignored
        snap();
        mode = MODE_SINGLE;
        step(1'b0, DTYPE_NONE, 12'd0, 1'b1, 1'b1);
        idle(1);
        check("t5_busy", busy, 0);
        frame(2, 4, -1);
        idle(2);
        check("t5_no_words", (out_fs + out_px + out_fe + out_other) -
                             (b_fs + b_px + b_fe + b_other), 0);

        // Asynchronous reset mid-frame, then capture from a fresh FRAME_START
        mode = MODE_CONT;
        step(1'b0, DTYPE_NONE, 12'd0, 1'b1, 1'b0);
        step(1'b1, DTYPE_FRAME_START, 12'h0F1, 1'b0, 1'b0);
        step(1'b1, DTYPE_ROW_START, 12'h0A0, 1'b0, 1'b0);
        step(1'b1, DTYPE_PIXEL, 12'h005, 1'b0, 1'b0);
        step(1'b1, DTYPE_PIXEL, 12'h006, 1'b0, 1'b0);
        check("t6_pre_busy", busy, 1);
        #2 resetb = 1'b0;
        #1;
        check("t6_rst_dvo", dvo, 0);
        check("t6_rst_datao", datao, 0);
        check("t6_rst_dtypeo", dtypeo, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_fc", frames_captured, 0);
        check("t6_rst_lfp", last_frame_pixels, 0);
        idle(1);
        resetb = 1'b1;
        snap();
        mode = MODE_SINGLE;
        step(1'b0, DTYPE_NONE, 12'd0, 1'b1, 1'b0);
        step(1'b1, DTYPE_PIXEL, 12'h007, 1'b0, 1'b0);
        step(1'b1, DTYPE_ROW_END, 12'h0B0, 1'b0, 1'b0);
        step(1'b1, DTYPE_FRAME_END, 12'hABC, 1'b0, 1'b0);
        idle(2);
        check("t6_tail_ignored", (out_px + out_fe) - (b_px + b_fe), 0);
        frame(2, 4, -1);
        idle(2);
        check("t6_fs", out_fs - b_fs, 1);
        check("t6_px", out_px - b_px, 8);
        check("t6_lfp", last_frame_pixels, 8);
        check("t6_done", done_cnt - b_done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
